mem_bus_arbiter: RTL

//  Shares one SRAM-like memory port between the instruction-fetch requester and the data-memory requester.
//  It sits between the pipeline and the AXI bridge, and has one transaction outstanding at a time.
//  It generates the stallreq_from_if / stallreq_from_mem inputs consumed by the datapath hazard unit.

---
 rtl/mem_bus_arbiter_if.sv | 53 +++++
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the pipeline, the arbiter and the shared SRAM-like bus.
// master = arbiter view, slave = environment (pipeline + bus slave) view. bus_err exists only with BUS_TIMEOUT_EN.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;
    logic              stallreq_from_if;
    logic              stallreq_from_mem;
`ifdef BUS_TIMEOUT_EN
    logic              bus_err;
`endif

    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata, stallreq_from_if, stallreq_from_mem
`ifdef BUS_TIMEOUT_EN
        , output bus_err
`endif
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata, stallreq_from_if, stallreq_from_mem
`ifdef BUS_TIMEOUT_EN
        , input bus_err
`endif
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto one SRAM-like port, one transaction in flight, data has priority.
// Optional data-phase watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.master bif
);
    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

    state_t            state, nextState;
    logic              reqQ, wrQ;
    logic [1:0]        sizeQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic              inAddr, inData, timeoutHit;
    logic              instAddrOk, instDataOk, dataAddrOk, dataDataOk;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    assign inAddr = (state == I_ADDR) || (state == D_ADDR);
    assign inData = (state == I_DATA) || (state == D_DATA);

`ifdef BUS_TIMEOUT_EN
    logic [15:0] waitCnt, waitCntInc;

    // Fires on the cycle whose increment would reach the limit, so a limit of N
    // ends the wait on the Nth cycle spent in *_DATA; a real data_ok wins.
    assign waitCntInc = waitCnt + 16'd1;
    assign timeoutHit = inData && !bif.bus_data_ok && (waitCntInc == 16'(TIMEOUT_CYCLES));
    assign bif.bus_err = timeoutHit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          waitCnt <= '0;
        else if (inAddr && bif.bus_addr_ok)   waitCnt <= '0;
        else if (inData && !bif.bus_data_ok)  waitCnt <= waitCntInc;
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bif.data_req)      nextState = D_ADDR;
                else if (bif.inst_req) nextState = I_ADDR;
            end
            I_ADDR:  if (bif.bus_addr_ok)               nextState = I_DATA;
            D_ADDR:  if (bif.bus_addr_ok)               nextState = D_DATA;
            I_DATA:  if (bif.bus_data_ok || timeoutHit) nextState = IDLE;
            D_DATA:  if (bif.bus_data_ok || timeoutHit) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        instAddrOk = 1'b0;
        instDataOk = 1'b0;
        dataAddrOk = 1'b0;
        dataDataOk = 1'b0;
        case (state)
            I_ADDR:  instAddrOk = bif.bus_addr_ok;
            I_DATA:  instDataOk = bif.bus_data_ok | timeoutHit;
            D_ADDR:  dataAddrOk = bif.bus_addr_ok;
            D_DATA:  dataDataOk = bif.bus_data_ok | timeoutHit;
            default: ;
        endcase
    end

    // Payload is captured only in IDLE so requester changes mid-access are invisible to the slave.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reqQ   <= 1'b0;
            wrQ    <= 1'b0;
            sizeQ  <= 2'd0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else begin
            reqQ <= (nextState == I_ADDR) || (nextState == D_ADDR);
            if (state == IDLE) begin
                if (bif.data_req) begin
                    wrQ    <= bif.data_wr;
                    sizeQ  <= bif.data_size;
                    addrQ  <= bif.data_addr;
                    wdataQ <= bif.data_wdata;
                end else if (bif.inst_req) begin
                    wrQ    <= 1'b0;
                    sizeQ  <= 2'b10;
                    addrQ  <= bif.inst_addr;
                    wdataQ <= '0;
                end
            end
        end
    end

    assign bif.bus_req   = reqQ;
    assign bif.bus_wr    = wrQ;
    assign bif.bus_size  = sizeQ;
    assign bif.bus_addr  = addrQ;
    assign bif.bus_wdata = wdataQ;

    assign bif.inst_addr_ok = instAddrOk;
    assign bif.inst_data_ok = instDataOk;
    assign bif.data_addr_ok = dataAddrOk;
    assign bif.data_data_ok = dataDataOk;
    assign bif.inst_rdata   = timeoutHit ? '0 : bif.bus_rdata;
    assign bif.data_rdata   = timeoutHit ? '0 : bif.bus_rdata;

    assign bif.stallreq_from_if  = (bif.inst_req | (state == I_ADDR) | (state == I_DATA)) & ~instDataOk;
    assign bif.stallreq_from_mem = (bif.data_req | (state == D_ADDR) | (state == D_DATA)) & ~dataDataOk;
endmodule
